// File: rtl/ps_tx_scheduler_if.sv
// Byte-source and serializer-side signals of the transmit scheduler.
// master = packet sources / serializer side, slave = the scheduler.
interface ps_tx_scheduler_if;
   logic [7:0] req0_data;
   logic       req0_valid;
   logic       req0_last;
   logic       req0_ready;
   logic [7:0] req1_data;
   logic       req1_valid;
   logic       req1_last;
   logic       req1_ready;
   logic [7:0] data_out;
   logic       valid_out;
   logic [1:0] grant;
   logic       skp_active;

   modport master (
      output req0_data, req0_valid, req0_last,
      output req1_data, req1_valid, req1_last,
      input  req0_ready, req1_ready,
      input  data_out, valid_out, grant, skp_active
   );

   modport slave (
      input  req0_data, req0_valid, req0_last,
      input  req1_data, req1_valid, req1_last,
      output req0_ready, req1_ready,
      output data_out, valid_out, grant, skp_active
   );
endinterface

// File: rtl/ps_tx_scheduler.sv
// Per-packet round-robin byte scheduler feeding the serializer, with periodic
// skip ordered sets (COM + SKP_LEN x SKP) inserted only at packet boundaries.
module ps_tx_scheduler #(
   parameter int unsigned SKP_INTERVAL = 64,
   parameter int unsigned SKP_LEN      = 3,
   parameter logic [7:0]  COM_SYM      = 8'hBC,
   parameter logic [7:0]  SKP_SYM      = 8'h1C
) (
   input logic            clk_4f,
   input logic            reset,
   input logic            enable,
   ps_tx_scheduler_if.slave bus
);

   localparam int unsigned CNT_W = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
   localparam int unsigned SUB_W = $clog2(SKP_LEN + 2);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SKP_INTERVAL - 1);
   localparam logic [SUB_W-1:0] SUB_DONE = SUB_W'(SKP_LEN + 1);

   typedef enum logic [1:0] {IDLE, XFER, SKP} state_t;

   state_t           state, state_nxt;
   logic [1:0]       grant_q, grant_nxt;
   logic             rr_q, rr_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic [SUB_W-1:0] sub_q, sub_nxt;
   logic [7:0]       data_q, data_nxt;
   logic             valid_q, valid_nxt;
   logic             skp_q, skp_nxt;

   logic       owner;
   logic       skp_pending;
   logic       own_valid;
   logic       own_last;
   logic [7:0] own_data;
   logic       accept;

   assign owner       = grant_q[1];
   assign skp_pending = (cnt_q == CNT_MAX);
   assign own_valid   = owner ? bus.req1_valid : bus.req0_valid;
   assign own_last    = owner ? bus.req1_last  : bus.req0_last;
   assign own_data    = owner ? bus.req1_data  : bus.req0_data;
   assign accept      = (state == XFER) && own_valid;

   assign bus.req0_ready = (state == XFER) && !owner && !reset;
   assign bus.req1_ready = (state == XFER) &&  owner && !reset;
   assign bus.data_out   = data_q;
   assign bus.valid_out  = valid_q;
   assign bus.grant      = grant_q;
   assign bus.skp_active = skp_q;

   always_ff @(posedge clk_4f) begin
      if (reset) begin
         state   <= IDLE;
         grant_q <= '0;
         rr_q    <= 1'b0;
         cnt_q   <= '0;
         sub_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         skp_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         grant_q <= grant_nxt;
         rr_q    <= rr_nxt;
         cnt_q   <= cnt_nxt;
         sub_q   <= sub_nxt;
         data_q  <= data_nxt;
         valid_q <= valid_nxt;
         skp_q   <= skp_nxt;
      end
   end

   // sub_q = index of the next ordered-set byte: entering from IDLE emits COM
   // on the entry edge (sub=1); entering after a last byte starts at sub=0.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant_q;
      rr_nxt    = rr_q;
      sub_nxt   = sub_q;
      data_nxt  = data_q;
      valid_nxt = 1'b0;
      skp_nxt   = 1'b0;
      if (state == SKP)
         cnt_nxt = '0;
      else if (skp_pending)
         cnt_nxt = cnt_q;
      else
         cnt_nxt = cnt_q + 1'b1;

      case (state)
         IDLE: begin
            if (skp_pending) begin
               state_nxt = SKP;
               data_nxt  = COM_SYM;
               valid_nxt = 1'b1;
               skp_nxt   = 1'b1;
               sub_nxt   = SUB_W'(1);
            end else if (enable && (bus.req0_valid || bus.req1_valid)) begin
               state_nxt = XFER;
               if (bus.req0_valid && bus.req1_valid)
                  grant_nxt = rr_q ? 2'b10 : 2'b01;
               else
                  grant_nxt = bus.req1_valid ? 2'b10 : 2'b01;
            end
         end
         XFER: begin
            if (accept) begin
               data_nxt  = own_data;
               valid_nxt = 1'b1;
               if (own_last) begin
                  grant_nxt = '0;
                  rr_nxt    = ~owner;
                  sub_nxt   = '0;
                  state_nxt = skp_pending ? SKP : IDLE;
               end
            end
         end
         SKP: begin
            if (sub_q == SUB_DONE) begin
               state_nxt = IDLE;
            end else begin
               data_nxt  = (sub_q == '0) ? COM_SYM : SKP_SYM;
               valid_nxt = 1'b1;
               skp_nxt   = 1'b1;
               sub_nxt   = sub_q + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ps_tx_scheduler.sv
// Directed bench for ps_tx_scheduler: source BFMs, a data scoreboard and an
// ordered-set checker, plus cycle-exact checks in one directed sequence.
module tb_ps_tx_scheduler;

   localparam int unsigned SKP_LEN = 3;

   logic clk_4f = 1'b0;
   logic reset;
   logic enable;

   ps_tx_scheduler_if bus ();

   ps_tx_scheduler #(
      .SKP_INTERVAL(64),
      .SKP_LEN     (SKP_LEN),
      .COM_SYM     (8'hBC),
      .SKP_SYM     (8'h1C)
   ) dut (
      .clk_4f(clk_4f),
      .reset (reset),
      .enable(enable),
      .bus   (bus)
   );

   always #5 clk_4f = ~clk_4f;

   int vectors = 0;
   int miscompares = 0;

   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [7:0] exp_q[$];
   logic hold0 = 1'b0;
   logic fire0, fire1;
   int   os_idx = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_4f);
      #1;
   endtask

   task automatic send(input int src, input logic [7:0] d, input logic last);
      if (src == 0) q0.push_back({last, d});
      else          q1.push_back({last, d});
      exp_q.push_back(d);
   endtask

   task automatic flush();
      q0.delete();
      q1.delete();
      exp_q.delete();
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      tick(1);
      flush();
      hold0 = 1'b0;
      tick(1);
      reset = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_data"},   32'(bus.data_out),   32'h00);
      chk({tag, "_valid"},  32'(bus.valid_out),  32'h0);
      chk({tag, "_grant"},  32'(bus.grant),      32'h0);
      chk({tag, "_skp"},    32'(bus.skp_active), 32'h0);
      chk({tag, "_ready0"}, 32'(bus.req0_ready), 32'h0);
      chk({tag, "_ready1"}, 32'(bus.req1_ready), 32'h0);
   endtask

   task automatic chk_out(input string tag, input logic [7:0] d, input logic skp);
      chk({tag, "_valid"}, 32'(bus.valid_out),  32'h1);
      chk({tag, "_data"},  32'(bus.data_out),   32'(d));
      chk({tag, "_skp"},   32'(bus.skp_active), 32'(skp));
   endtask

   task automatic drain(input string tag, input int bound);
      int n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         tick(1);
         n++;
      end
      chk({tag, "_drain"}, 32'(exp_q.size()), 32'h0);
   endtask

   initial begin : bfm0
      bus.req0_valid = 1'b0;
      bus.req0_data  = 8'h00;
      bus.req0_last  = 1'b0;
      forever begin
         @(negedge clk_4f);
         fire0 = bus.req0_valid && bus.req0_ready;
         @(posedge clk_4f);
         if (fire0 && q0.size() > 0) void'(q0.pop_front());
         #2;
         if (q0.size() > 0 && !hold0) begin
            bus.req0_valid = 1'b1;
            {bus.req0_last, bus.req0_data} = q0[0];
         end else begin
            bus.req0_valid = 1'b0;
         end
      end
   end

   initial begin : bfm1
      bus.req1_valid = 1'b0;
      bus.req1_data  = 8'h00;
      bus.req1_last  = 1'b0;
      forever begin
         @(negedge clk_4f);
         fire1 = bus.req1_valid && bus.req1_ready;
         @(posedge clk_4f);
         if (fire1 && q1.size() > 0) void'(q1.pop_front());
         #2;
         if (q1.size() > 0) begin
            bus.req1_valid = 1'b1;
            {bus.req1_last, bus.req1_data} = q1[0];
         end else begin
            bus.req1_valid = 1'b0;
         end
      end
   end

   // Scoreboard for packet bytes and structural check of ordered sets.
   initial begin : monitor
      forever begin
         @(negedge clk_4f);
         if (reset) begin
            os_idx = 0;
         end else if (bus.valid_out) begin
            if (bus.skp_active) begin
               chk("os_symbol", 32'(bus.data_out), (os_idx == 0) ? 32'hBC : 32'h1C);
               os_idx = (os_idx == int'(SKP_LEN)) ? 0 : os_idx + 1;
            end else begin
               chk("os_complete_before_data", 32'(os_idx), 32'h0);
               chk("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'h1);
               if (exp_q.size() != 0)
                  chk("sb_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
            end
         end else begin
            chk("skp_idle", 32'(bus.skp_active), 32'h0);
            if (os_idx != 0) chk("os_gap", 32'(os_idx), 32'h0);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "simulation timeout");
   end

   initial begin : stim
      int n;
      logic any_v;
      reset  = 1'b1;
      enable = 1'b1;

      // Reset state, idle skip cadence
      tick(2);
      chk_reset_vals("rst");
      reset = 1'b0;
      any_v = 1'b0;
      for (int k = 1; k <= 63; k++) begin
         tick(1);
         if (bus.valid_out) any_v = 1'b1;
      end
      chk("idle_before_skp", 32'(any_v), 32'h0);
      tick(1);
      chk_out("first_com", 8'hBC, 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick(1);
         chk_out("first_skp", 8'h1C, 1'b1);
      end
      tick(1);
      chk("os_end_valid", 32'(bus.valid_out), 32'h0);
      chk("os_end_skp", 32'(bus.skp_active), 32'h0);
      n = 0;
      while (!bus.valid_out && n < 200) begin
         tick(1);
         n++;
      end
      chk("skp_period", 32'(n), 32'd64);
      chk("second_com", 32'(bus.data_out), 32'hBC);
      tick(4);

      // Single source packet
      reset_dut();
      send(0, 8'h11, 1'b0);
      send(0, 8'h22, 1'b0);
      send(0, 8'h33, 1'b1);
      tick(1);
      chk("s0_grant", 32'(bus.grant), 32'h1);
      chk("s0_ready0", 32'(bus.req0_ready), 32'h1);
      chk("s0_ready1", 32'(bus.req1_ready), 32'h0);
      chk("s0_gnt_cycle_valid", 32'(bus.valid_out), 32'h0);
      tick(1); chk_out("s0_b0", 8'h11, 1'b0);
      tick(1); chk_out("s0_b1", 8'h22, 1'b0);
      tick(1); chk_out("s0_b2", 8'h33, 1'b0);
      chk("s0_grant_clear", 32'(bus.grant), 32'h0);
      chk("s0_ready_clear", 32'(bus.req0_ready), 32'h0);
      tick(1);
      chk("s0_after_valid", 32'(bus.valid_out), 32'h0);
      chk("s0_hold_data", 32'(bus.data_out), 32'h33);
      drain("s0", 5);

      // Round robin with both sources continuously valid
      reset_dut();
      for (int p = 0; p < 3; p++) begin
         send(0, 8'hA0, 1'b0);
         send(0, 8'hA1, 1'b1);
         send(1, 8'hB0, 1'b0);
         send(1, 8'hB1, 1'b1);
      end
      tick(1); chk("rr_grant0", 32'(bus.grant), 32'h1);
      tick(2); chk_out("rr_a1", 8'hA1, 1'b0);
      tick(1); chk("rr_grant1", 32'(bus.grant), 32'h2);
      chk("rr_gap", 32'(bus.valid_out), 32'h0);
      tick(1); chk_out("rr_b0", 8'hB0, 1'b0);
      tick(2); chk("rr_grant2", 32'(bus.grant), 32'h1);
      drain("rr", 30);

      // Skip pending mid-packet waits for last byte; competitor waits for skip
      reset_dut();
      tick(59);
      for (int b = 0; b < 6; b++) send(0, 8'(8'h40 + b), (b == 5));
      send(1, 8'h50, 1'b0);
      send(1, 8'h51, 1'b1);
      tick(1); chk("sp_grant", 32'(bus.grant), 32'h1);
      tick(5);
      chk_out("sp_b4", 8'h44, 1'b0);
      chk("sp_ready1", 32'(bus.req1_ready), 32'h0);
      tick(1); chk_out("sp_last", 8'h45, 1'b0);
      tick(1); chk_out("sp_com", 8'hBC, 1'b1);
      chk("sp_ready1_os", 32'(bus.req1_ready), 32'h0);
      tick(3); chk_out("sp_skp3", 8'h1C, 1'b1);
      tick(1);
      chk("sp_end_valid", 32'(bus.valid_out), 32'h0);
      chk("sp_end_grant", 32'(bus.grant), 32'h0);
      tick(1); chk("sp_grant1", 32'(bus.grant), 32'h2);
      drain("sp", 10);

      // Owner bubble
      reset_dut();
      send(0, 8'hC0, 1'b0);
      send(0, 8'hC1, 1'b0);
      send(0, 8'hC2, 1'b0);
      send(0, 8'hC3, 1'b1);
      send(1, 8'hD0, 1'b1);
      tick(1); chk("bb_grant", 32'(bus.grant), 32'h1);
      tick(1); chk_out("bb_c0", 8'hC0, 1'b0);
      hold0 = 1'b1;
      tick(1);
      chk("bb_gap1_valid", 32'(bus.valid_out), 32'h0);
      chk("bb_gap1_data", 32'(bus.data_out), 32'hC0);
      chk("bb_gap1_grant", 32'(bus.grant), 32'h1);
      chk("bb_gap1_ready1", 32'(bus.req1_ready), 32'h0);
      tick(1);
      chk("bb_gap2_valid", 32'(bus.valid_out), 32'h0);
      chk("bb_gap2_grant", 32'(bus.grant), 32'h1);
      hold0 = 1'b0;
      tick(1); chk_out("bb_c1", 8'hC1, 1'b0);
      drain("bb", 15);

      // Reset mid ordered set
      reset_dut();
      tick(65);
      chk_out("ro_skp1", 8'h1C, 1'b1);
      reset = 1'b1;
      tick(1);
      chk_reset_vals("ro");

      // Reset mid packet, then rr pointer and skip timer restart
      reset_dut();
      send(0, 8'hE0, 1'b1);
      send(1, 8'hF0, 1'b0);
      send(1, 8'hF1, 1'b0);
      send(1, 8'hF2, 1'b1);
      tick(1); chk("rp_grant0", 32'(bus.grant), 32'h1);
      tick(1); chk_out("rp_e0", 8'hE0, 1'b0);
      tick(1); chk("rp_grant1", 32'(bus.grant), 32'h2);
      tick(1); chk_out("rp_f0", 8'hF0, 1'b0);
      reset = 1'b1;
      tick(1);
      chk_reset_vals("rp");
      flush();
      tick(1);
      reset = 1'b0;
      send(0, 8'h60, 1'b1);
      send(1, 8'h70, 1'b1);
      tick(1); chk("rp_tie_src0", 32'(bus.grant), 32'h1);
      tick(62);
      chk("rp_pre_com", 32'(bus.valid_out), 32'h0);
      chk("rp_sb_done", 32'(exp_q.size()), 32'h0);
      tick(1); chk_out("rp_com", 8'hBC, 1'b1);
      tick(4);
      chk("rp_os_end", 32'(bus.valid_out), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ps_tx_scheduler.md
Name: ps_tx_scheduler

Overview:
Byte-level transmit scheduler that sits directly upstream of the parallel-to-serial stage. It arbitrates two packetized byte sources (valid/ready/last) onto the serializer's single 8-bit data_in/valid_in pair, with round-robin per packet. It also inserts a skip ordered set periodically, at packet boundaries only, to maintain the link. The ordered set is one COM symbol (0xBC) followed by SKP_LEN SKP symbols (0x1C). When nothing is scheduled, valid_out stays low and the serializer sends its idle COM.

Parameters:
SKP_INTERVAL, 64, clk_4f cycles counted before a skip ordered set becomes pending
SKP_LEN, 3, number of SKP symbols after the COM in one ordered set (min 1)
COM_SYM, 8'hBC, COM symbol value
SKP_SYM, 8'h1C, SKP symbol value

Ports:
clk_4f  in  1  byte clock shared with the serializer load side
reset  in  1  synchronous, active-high
enable  in  1  permits new packet grants; does not gate skip insertion
req0_data  in  8  source 0 byte
req0_valid  in  1  source 0 byte valid
req0_last  in  1  source 0 final byte of packet
req0_ready  out  1  source 0 byte accepted this cycle when high with req0_valid
req1_data  in  8  source 1 byte
req1_valid  in  1  source 1 byte valid
req1_last  in  1  source 1 final byte of packet
req1_ready  out  1  source 1 handshake
data_out  out  8  byte to serializer data_in
valid_out  out  1  to serializer valid_in
grant  out  2  one-hot current packet owner; 00 when none
skp_active  out  1  high while an ordered-set byte is on data_out

Behaviour:
- Reset is synchronous, active-high, on clk_4f. Reset values: data_out=8'h00, valid_out=0, grant=00, skp_active=0, req0_ready=req1_ready=0, state=IDLE, rr pointer=0 (source 0 preferred), skip counter=0, skp_pending=0.
- Reset mid-packet or mid-ordered-set aborts immediately. No completion and no COM flush.
- States:
  - IDLE: no owner.
  - XFER: owner register valid.
  - SKP: sub-counter 0..SKP_LEN.
- reqN_ready is combinational: high iff state==XFER, owner==N and reset==0.
- A byte is accepted on an edge where reqN_valid and reqN_ready are both high.
- data_out/valid_out are registered. An accepted byte appears on the next cycle (latency 1). A cycle with no accepted byte gives valid_out=0; data_out holds its previous value.
- Skip counter:
  - Increments every cycle when not in SKP, held at 0 in SKP, saturates at SKP_INTERVAL-1.
  - skp_pending = (cnt == SKP_INTERVAL-1).
  - Cleared to 0 on the edge leaving SKP.
- IDLE transitions, priority order:
  - skp_pending -> SKP.
  - Else if enable and any reqN_valid: if both valid, grant the source != rr pointer's last-served (rr pointer = next preferred); else grant the valid one. -> XFER, grant one-hot registered on the same edge.
  - Else stay.
- Grant costs one cycle; no byte is accepted in the IDLE cycle.
- XFER:
  - Stay while the owner has not delivered last.
  - Owner valid low inserts a bubble (valid_out=0); the packet is not abandoned.
  - Edge accepting the last byte: rr pointer flips to the other source, grant clears to 00, next state = SKP if skp_pending else IDLE.
  - A skip never interrupts a packet; pending waits for last.
- SKP:
  - Entry edge drives data_out=COM_SYM, valid_out=1, skp_active=1.
  - The next SKP_LEN edges drive SKP_SYM with valid_out=1, skp_active=1.
  - The edge after the final SKP byte drives valid_out=0, skp_active=0 and goes to IDLE.
  - Ordered set occupies exactly 1+SKP_LEN consecutive valid cycles.
  - Both readies are low throughout.
- enable deasserted during XFER: the current packet completes normally; no new grant until enable returns. Skips continue while enable=0.
- Source valid while not granted: must hold data stable; the block never drops it.
- Simultaneous last acceptance and skp_pending: the last byte is output, then COM on the following cycle (no IDLE gap).

Test Plan:
- Reset release, no requests, enable=1 -> valid_out=0 until cnt saturates. Then BC,1C,1C,1C on four consecutive cycles with skp_active=1, then valid_out=0. The next COM follows after a further SKP_INTERVAL-cycle count.
- Source 0 only: packet 0x11,0x22,0x33(last) -> grant=01 one cycle after valid; data_out 11,22,33 on consecutive cycles with latency 1; grant=00 after last.
- Both sources valid continuously with 2-byte packets (0xA0,0xA1 / 0xB0,0xB1) -> output A0,A1,B0,B1,A0,A1… with one idle cycle between packets; grant alternates 01/10.
- Skip becomes pending mid-packet of 6 bytes -> all 6 bytes out uninterrupted, then BC,1C,1C,1C immediately after the last byte; a competing request is granted only afterwards.
- Owner drops valid for 2 cycles mid-packet -> valid_out=0 for 2 cycles; grant held; the other source's ready stays 0.
- Reset asserted mid-ordered-set and mid-packet -> next cycle all outputs at reset values; after release source 0 wins first tie; skip timing restarts from 0.
